// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Types shared by the memory controller and the RAM responder.
//   word_t     : 32-bit data/address word
//   ramstate_t : RAM bus handshake state (FREE, BUSY, ACCESS, ERROR)
//   RAM_LAT_W  : width of the RAM access-latency counter
//   ram_req_t  : latched copy of one RAM request {ren, wen, addr}
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_W = 4;

    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
    } ram_req_t;

endpackage

// File: rtl/ram_lat_counter.sv
// ---------------------------------------------------------------------------
// ram_lat_counter
// Loadable down-counter that times the BUSY phase of a RAM access.
// Ports:
//   CLK, nRST  : clock, asynchronous active-low reset (count clears to 0)
//   i_load     : load i_val for a fresh request
//   i_restart  : reload i_val because the held request changed mid-access
//   i_dec      : count down by one (holds at zero)
//   i_val      : reload value (LAT-1)
//   o_zero     : count is zero
// ---------------------------------------------------------------------------
module ram_lat_counter
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 i_load,
    input  logic                 i_restart,
    input  logic                 i_dec,
    input  logic [RAM_LAT_W-1:0] i_val,
    output logic                 o_zero
);

    logic [RAM_LAT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (i_load || i_restart) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
// RAM-side responder for the memory controller's RAM request bus. Holds a
// DEPTH x 32-bit word array, serves single-word reads/writes after LAT BUSY
// cycles and reports progress on ramstate.
// Ports:
//   CLK, nRST        : clock (rising edge), asynchronous active-low reset
//   ramREN, ramWEN   : read / write request, held by the requester until ACCESS
//   ramaddr          : byte address, bits [1:0] ignored
//   ramstore         : write data, sampled in the ACCESS cycle
//   ramload          : read data, non-zero only in the ACCESS cycle of a read
//   ramstate         : FREE / BUSY / ACCESS / ERROR
//   rd_count, wr_count, err_count : saturating activity counters
//                      (present only when RAM_STATS_EN is defined)
// Optional build macro: RAM_STATS_EN
// ---------------------------------------------------------------------------
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
`ifdef RAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);

    // LAT=0 never enters BUSY, so the reload value is only meaningful for LAT>0.
    localparam logic [RAM_LAT_W-1:0] LAT_LOAD = (LAT == 0) ? '0 : RAM_LAT_W'(LAT - 1);

    ramstate_t r_state;
    ramstate_t w_next;
    ram_req_t  r_req;
    ram_req_t  w_req;
    word_t     r_mem [DEPTH];

    logic             w_any;
    logic             w_in_range;
    logic             w_legal;
    logic             w_illegal;
    logic             w_changed;
    logic             w_latch;
    logic             w_load;
    logic             w_restart;
    logic             w_dec;
    logic             w_zero;
    logic [IDX_W-1:0] w_idx;

    // Byte-lane bits are masked so a change there does not restart an access.
    assign w_req      = '{ren: ramREN, wen: ramWEN, addr: {ramaddr[31:2], 2'b00}};
    assign w_any      = ramREN | ramWEN;
    assign w_in_range = (ramaddr[31:IDX_W+2] == '0);
    assign w_legal    = (ramREN ^ ramWEN) & w_in_range;
    assign w_illegal  = (ramREN & ramWEN) | (w_any & ~w_in_range);
    assign w_changed  = (w_req != r_req);
    assign w_idx      = r_req.addr[IDX_W+1:2];

    ram_lat_counter u_lat (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_load    (w_load),
        .i_restart (w_restart),
        .i_dec     (w_dec),
        .i_val     (LAT_LOAD),
        .o_zero    (w_zero)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FREE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched request; array contents are deliberately not reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_req <= '0;
        end else if (w_latch) begin
            r_req <= w_req;
        end
    end

    // Reset forces FREE asynchronously, so an aborted write can never commit here.
    always_ff @(posedge CLK) begin
        if ((r_state == ACCESS) && r_req.wen) begin
            r_mem[w_idx] <= ramstore;
        end
    end

    // Next-state logic
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_load    = 1'b0;
        w_restart = 1'b0;
        w_dec     = 1'b0;
        case (r_state)
            FREE: begin
                if (w_illegal) begin
                    w_next = ERROR;
                end else if (w_legal) begin
                    w_latch = 1'b1;
                    if (LAT == 0) begin
                        w_next = ACCESS;
                    end else begin
                        w_next = BUSY;
                        w_load = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (w_illegal) begin
                    w_next = ERROR;
                end else if (!w_any) begin
                    w_next = FREE;
                end else if (w_changed) begin
                    w_latch   = 1'b1;
                    w_restart = 1'b1;
                end else if (w_zero) begin
                    w_next = ACCESS;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ACCESS: w_next = FREE;
            ERROR: begin
                if (!w_any) begin
                    w_next = FREE;
                end
            end
            default: w_next = FREE;
        endcase
    end

    // Outputs
    always_comb begin
        ramstate = r_state;
        ramload  = '0;
        if ((r_state == ACCESS) && r_req.ren) begin
            ramload = r_mem[w_idx];
        end
    end

`ifdef RAM_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if ((r_state == ACCESS) && r_req.ren && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if ((r_state == ACCESS) && r_req.wen && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            // Count entries only, not cycles spent in ERROR.
            if ((r_state != ERROR) && (w_next == ERROR) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign rd_count  = r_rd_cnt;
    assign wr_count  = r_wr_cnt;
    assign err_count = r_err_cnt;
`endif

endmodule
